// File: rtl/osd_spi_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : osd_spi_loader                                                 |
// | Desc    : SPI master and command sequencer for the OSD overlay. Sends    |
// |           enable/disable commands and streams 256-byte line writes.      |
// | Rev     : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module osd_spi_loader #(
    parameter int CLK_DIV = 4,
    parameter int SS_GAP  = 8
) (
    input  logic       pclk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_type,
    input  logic [2:0] cmd_line,
    output logic       rd_req,
    output logic [7:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic       busy,
    output logic       done,
    output logic       sck,
    output logic       ss,
    output logic       sdi
);

    localparam int c_TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_GW = (SS_GAP > 1) ? $clog2(SS_GAP + 1) : 1;
    localparam logic [c_TW-1:0] c_TLOAD = c_TW'(CLK_DIV - 1);
    localparam logic [c_GW-1:0] c_GAP   = c_GW'(SS_GAP);

    localparam logic [7:0] c_CMD_DISABLE = 8'h40;
    localparam logic [7:0] c_CMD_ENABLE  = 8'h41;
    localparam logic [4:0] c_WRITE_PFX   = 5'b00100;
    localparam logic [1:0] c_TYPE_WRITE  = 2'b10;
    localparam logic [1:0] c_TYPE_NOP    = 2'b11;

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_SELECT   = 3'd1;
    localparam logic [2:0] c_FETCH    = 3'd2;
    localparam logic [2:0] c_BIT_LO   = 3'd3;
    localparam logic [2:0] c_BIT_HI   = 3'd4;
    localparam logic [2:0] c_DESELECT = 3'd5;

    logic [2:0]      r_state;
    logic [c_TW-1:0] r_timer;
    logic [c_GW-1:0] r_gap;
    logic [2:0]      r_bitcnt;
    logic [7:0]      r_shift;
    logic [1:0]      r_type;
    logic [2:0]      r_line;
    logic            r_last;
    logic [7:0]      r_rd_addr;
    logic            r_rd_req;
    logic            r_busy;
    logic            r_done;
    logic            r_sck;
    logic            r_ss;
    logic            r_sdi;
    logic [7:0]      w_cmd_byte;
    logic            w_cmd_ready;

    always_comb begin
        w_cmd_byte = c_CMD_DISABLE;
        case (r_type)
            2'b01:        w_cmd_byte = c_CMD_ENABLE;
            c_TYPE_WRITE: w_cmd_byte = {c_WRITE_PFX, r_line};
            default:      w_cmd_byte = c_CMD_DISABLE;
        endcase
    end

    assign w_cmd_ready = (r_state == c_IDLE) && (r_gap == '0);

    always_ff @(posedge pclk) begin
        if (reset) begin
            r_state   <= c_IDLE;
            r_timer   <= '0;
            r_gap     <= c_GAP;
            r_bitcnt  <= 3'd0;
            r_shift   <= 8'd0;
            r_type    <= 2'b00;
            r_line    <= 3'd0;
            r_last    <= 1'b0;
            r_rd_addr <= 8'd0;
            r_rd_req  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_sck     <= 1'b0;
            r_ss      <= 1'b1;
            r_sdi     <= 1'b0;
        end else begin
            r_done   <= 1'b0;
            r_rd_req <= 1'b0;
            if (r_gap != '0)
                r_gap <= r_gap - 1'b1;

            case (r_state)
                c_IDLE: begin
                    r_busy <= 1'b0;
                    if (cmd_valid && w_cmd_ready) begin
                        r_type <= cmd_type;
                        r_line <= cmd_line;
                        // A no-op is consumed here and never touches the bus
                        if (cmd_type != c_TYPE_NOP) begin
                            r_state   <= c_SELECT;
                            r_ss      <= 1'b0;
                            r_busy    <= 1'b1;
                            r_timer   <= c_TLOAD;
                            r_rd_addr <= 8'd0;
                            r_last    <= 1'b0;
                        end
                    end
                end

                c_SELECT: begin
                    if (r_timer == '0) begin
                        r_shift  <= w_cmd_byte;
                        r_sdi    <= w_cmd_byte[7];
                        r_bitcnt <= 3'd0;
                        r_timer  <= c_TLOAD;
                        r_state  <= c_BIT_LO;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end

                c_FETCH: begin
                    // First FETCH cycle issues the strobe; the second captures the byte
                    if (!r_rd_req) begin
                        r_shift   <= rd_data;
                        r_sdi     <= rd_data[7];
                        r_rd_addr <= r_rd_addr + 8'd1;
                        r_last    <= (r_rd_addr == 8'hFF);
                        r_bitcnt  <= 3'd0;
                        r_timer   <= c_TLOAD;
                        r_state   <= c_BIT_LO;
                    end
                end

                c_BIT_LO: begin
                    if (r_timer == '0) begin
                        r_sck   <= 1'b1;
                        r_timer <= c_TLOAD;
                        r_state <= c_BIT_HI;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end

                c_BIT_HI: begin
                    if (r_timer == '0) begin
                        r_sck    <= 1'b0;
                        r_shift  <= {r_shift[6:0], 1'b0};
                        r_bitcnt <= r_bitcnt + 3'd1;
                        r_timer  <= c_TLOAD;
                        if (r_bitcnt != 3'd7) begin
                            r_sdi   <= r_shift[6];
                            r_state <= c_BIT_LO;
                        end else if ((r_type == c_TYPE_WRITE) && !r_last) begin
                            r_rd_req <= 1'b1;
                            r_state  <= c_FETCH;
                        end else begin
                            r_sdi   <= 1'b0;
                            r_state <= c_DESELECT;
                        end
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end

                c_DESELECT: begin
                    if (r_timer == '0) begin
                        r_ss    <= 1'b1;
                        r_done  <= 1'b1;
                        r_gap   <= c_GAP;
                        r_state <= c_IDLE;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end

                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign cmd_ready = w_cmd_ready;
    assign rd_req    = r_rd_req;
    assign rd_addr   = r_rd_addr;
    assign busy      = r_busy;
    assign done      = r_done;
    assign sck       = r_sck;
    assign ss        = r_ss;
    assign sdi       = r_sdi;

endmodule
`default_nettype wire
